// File: rtl/alu_seq_if.sv
// Instruction push channel and register-file / ALU control outputs of the ALU sequencer.
// The master drives instructions in; the slave (the sequencer) drives control outputs.
interface alu_seq_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_cmd;
   logic [2:0]  instr_rs1;
   logic [2:0]  instr_rs2;
   logic [2:0]  instr_rd;
   logic [2:0]  rf_raddr_a;
   logic [2:0]  rf_raddr_b;
   logic [7:0]  alu_control_command;
   logic [2:0]  rf_waddr;
   logic        rf_we;
   logic        done;
   logic        illegal;
   logic        busy;

   modport master (
      output instr_valid, instr_cmd, instr_rs1, instr_rs2, instr_rd,
      input  instr_ready, rf_raddr_a, rf_raddr_b, alu_control_command,
      input  rf_waddr, rf_we, done, illegal, busy
   );

   modport slave (
      input  instr_valid, instr_cmd, instr_rs1, instr_rs2, instr_rd,
      output instr_ready, rf_raddr_a, rf_raddr_b, alu_control_command,
      output rf_waddr, rf_we, done, illegal, busy
   );
endinterface

// File: rtl/alu_sequencer.sv
// Queues instructions and steps each through READ -> EXEC (MUL_CYCLES for MUL) -> WB; push to WB is 3 edges when idle.
// Backpressure: instr_ready drops when the queue is full or reset is asserted; illegal commands are popped and discarded.
module alu_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic     clk,
   input  logic     reset_n,
   alu_seq_if.slave bus
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int MW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES + 1) : 1;

   typedef struct packed {
      logic [15:0] cmd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [2:0]  rd;
   } instr_t;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   state_t         state, state_nxt;
   instr_t         fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   instr_t         head, cur;
   logic [MW-1:0]  exec_cnt;
   logic           illegal_q;
   logic           full, empty, push, pop, head_legal;

   assign full            = (count == CW'(FIFO_DEPTH));
   assign empty           = (count == '0);
   assign bus.instr_ready = reset_n && !full;
   assign push            = bus.instr_valid && bus.instr_ready;
   assign head            = fifo_mem[rd_ptr];
   assign head_legal      = (head.cmd >= 16'h0001) && (head.cmd <= 16'h0010);
   // The only pop point: the edge leaving IDLE or WB.
   assign pop             = ((state == S_IDLE) || (state == S_WB)) && !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{cmd: bus.instr_cmd, rs1: bus.instr_rs1,
                                rs2: bus.instr_rs2, rd: bus.instr_rd};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cur       <= '0;
         exec_cnt  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= pop && !head_legal;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            cur    <= head;
         end
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         // Loaded while in READ so EXEC sees the remaining extra cycles.
         if (state == S_READ)
            exec_cnt <= (cur.cmd == 16'h0003) ? MW'(MUL_CYCLES - 1) : '0;
         else if ((state == S_EXEC) && (exec_cnt != '0))
            exec_cnt <= exec_cnt - MW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_WB: begin
            if (pop) state_nxt = head_legal ? S_READ : S_IDLE;
            else     state_nxt = S_IDLE;
         end
         S_READ: state_nxt = S_EXEC;
         S_EXEC: if (exec_cnt == '0) state_nxt = S_WB;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.rf_raddr_a          = '0;
      bus.rf_raddr_b          = '0;
      bus.alu_control_command = '0;
      bus.rf_waddr            = '0;
      bus.rf_we               = 1'b0;
      bus.done                = 1'b0;
      bus.illegal             = illegal_q;
      bus.busy                = (state != S_IDLE) || !empty;
      case (state)
         S_READ: begin
            bus.rf_raddr_a = cur.rs1;
            bus.rf_raddr_b = cur.rs2;
         end
         S_EXEC: begin
            bus.rf_raddr_a          = cur.rs1;
            bus.rf_raddr_b          = cur.rs2;
            bus.alu_control_command = cur.cmd[7:0];
         end
         S_WB: begin
            bus.rf_waddr = cur.rd;
            bus.done     = 1'b1;
            // Counter ops 0x000D-0x000F retire without a register write.
            bus.rf_we    = !((cur.cmd >= 16'h000D) && (cur.cmd <= 16'h000F));
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed stimulus against a transaction-level schedule model of the ALU sequencer.
module tb_alu_sequencer;

   localparam int DEPTH = 4;
   localparam int MULC  = 3;
   localparam int TL    = 4096;

   typedef struct packed {
      logic [15:0] cmd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [2:0]  rd;
   } instr_t;

   typedef struct packed {
      logic       act;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] alu;
      logic [2:0] wa;
      logic       we;
      logic       done;
      logic       ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   alu_seq_if bus ();

   alu_sequencer #(.FIFO_DEPTH(DEPTH), .MUL_CYCLES(MULC)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t   tl [TL];
   instr_t q [$];
   int     cyc = 0;
   int     free_edge = 0;
   bit     chk_en = 1'b0;
   int     errors = 0;
   int     checks = 0;
   int     obs_done = 0, exp_done = 0, obs_ill = 0, exp_ill = 0;

   function automatic void model_reset(input int e);
      q.delete();
      for (int i = e; i < TL; i++) tl[i] = '0;
      free_edge = e;
   endfunction

   // Place a popped instruction's whole lifetime into the expected timeline.
   function automatic void model_pop(input int e);
      instr_t it;
      int     ex;
      if (e < free_edge || q.size() == 0) return;
      it = q.pop_front();
      if (it.cmd < 16'h0001 || it.cmd > 16'h0010) begin
         tl[e].ill = 1'b1;
         free_edge = e + 1;
         return;
      end
      ex = (it.cmd == 16'h0003) ? MULC : 1;
      for (int k = 0; k <= ex; k++) begin
         tl[e+k].act = 1'b1;
         tl[e+k].ra  = it.rs1;
         tl[e+k].rb  = it.rs2;
         if (k > 0) tl[e+k].alu = it.cmd[7:0];
      end
      tl[e+ex+1].act  = 1'b1;
      tl[e+ex+1].wa   = it.rd;
      tl[e+ex+1].done = 1'b1;
      tl[e+ex+1].we   = !(it.cmd >= 16'h000D && it.cmd <= 16'h000F);
      free_edge = e + ex + 2;
   endfunction

   task automatic do_cycle(input logic v, input instr_t ins, input logic rst, output logic acc);
      exp_t        ex;
      logic        exp_rdy;
      logic [22:0] obs_v, exp_v;
      int          e;
      bus.instr_valid = v;
      bus.instr_cmd   = ins.cmd;
      bus.instr_rs1   = ins.rs1;
      bus.instr_rs2   = ins.rs2;
      bus.instr_rd    = ins.rd;
      reset_n         = !rst;
      #1;
      exp_rdy = !rst && (q.size() < DEPTH);
      if (chk_en) begin
         ex    = tl[cyc];
         exp_v = {ex.ra, ex.rb, ex.alu, ex.wa, ex.we, ex.done, ex.ill, (ex.act || q.size() > 0)};
         obs_v = {bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_control_command, bus.rf_waddr,
                  bus.rf_we, bus.done, bus.illegal, bus.busy};
         checks++;
         assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL outs cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
         end
         checks++;
         assert (bus.instr_ready === exp_rdy) else begin
            errors++;
            $error("FAIL instr_ready cyc=%0d observed=%b expected=%b", cyc, bus.instr_ready, exp_rdy);
         end
         if (bus.done === 1'b1)    obs_done++;
         if (bus.illegal === 1'b1) obs_ill++;
         if (ex.done) exp_done++;
         if (ex.ill)  exp_ill++;
      end
      acc = v && exp_rdy;
      @(posedge clk);
      e = cyc + 1;
      if (rst) model_reset(e);
      else begin
         model_pop(e);
         if (acc) q.push_back(ins);
      end
      cyc    = e;
      chk_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, acc);
   endtask

   task automatic push_hold(input instr_t ins);
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) do_cycle(1'b1, ins, 1'b0, acc);
      checks++;
      assert (acc) else begin
         errors++;
         $error("FAIL push_timeout cyc=%0d observed=0 expected=1", cyc);
      end
   endtask

   task automatic rst_cycles(input int n);
      logic acc;
      for (int i = 0; i < n; i++) do_cycle(1'b1, '{16'h0001, 3'd1, 3'd1, 3'd1}, 1'b1, acc);
   endtask

   initial begin
      logic   acc;
      instr_t r;
      int     sel;
      bus.instr_valid = 1'b0;
      bus.instr_cmd   = '0;
      bus.instr_rs1   = '0;
      bus.instr_rs2   = '0;
      bus.instr_rd    = '0;
      reset_n         = 1'b0;
      @(negedge clk);
      rst_cycles(2);
      idle(2);

      // Single ADD, then MUL, then counter op
      push_hold('{16'h0001, 3'd1, 3'd2, 3'd3});
      idle(5);
      push_hold('{16'h0003, 3'd4, 3'd5, 3'd6});
      idle(7);
      push_hold('{16'h000E, 3'd2, 3'd7, 3'd5});
      idle(5);

      // Fill the queue behind a stalled MUL
      push_hold('{16'h0003, 3'd1, 3'd1, 3'd0});
      for (int i = 1; i <= 5; i++) push_hold('{16'h0001, 3'(i), 3'(7 - i), 3'(i)});
      idle(25);

      // Illegal command sandwiched between ADDs
      push_hold('{16'h0001, 3'd1, 3'd2, 3'd3});
      push_hold('{16'h0011, 3'd4, 3'd4, 3'd4});
      push_hold('{16'h0001, 3'd5, 3'd6, 3'd7});
      idle(10);

      // Reset while a queued stream is executing
      push_hold('{16'h0003, 3'd1, 3'd2, 3'd3});
      push_hold('{16'h0002, 3'd3, 3'd2, 3'd1});
      push_hold('{16'h0004, 3'd6, 3'd5, 3'd4});
      rst_cycles(1);
      idle(10);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         sel   = $urandom_range(0, 9);
         r.cmd = (sel < 7) ? 16'($urandom_range(1, 16)) :
                 (sel == 7) ? 16'h0003 :
                 (sel == 8) ? 16'($urandom_range(0, 1) ? 0 : 17) : 16'($urandom);
         r.rs1 = 3'($urandom);
         r.rs2 = 3'($urandom);
         r.rd  = 3'($urandom);
         if ($urandom_range(0, 149) == 0) rst_cycles(1);
         else do_cycle($urandom_range(0, 2) != 0, r, 1'b0, acc);
      end
      idle(30);

      checks++;
      assert (obs_done === exp_done) else begin
         errors++;
         $error("FAIL done_count observed=%0d expected=%0d", obs_done, exp_done);
      end
      checks++;
      assert (obs_ill === exp_ill) else begin
         errors++;
         $error("FAIL illegal_count observed=%0d expected=%0d", obs_ill, exp_ill);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: instruction queue entries (power of 2, >=2).
REQ-002 Parameter MUL_CYCLES, default 3: EXEC cycles for MUL (>=1).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  reset is synchronous and active-low.
REQ-005 instr_valid  in  1  upstream instruction present.
REQ-006 instr_ready  out  1  queue can accept; equals NOT full.
REQ-007 instr_cmd  in  16  command code; legal values 0x0001-0x0010.
REQ-008 instr_rs1 / instr_rs2 / instr_rd  in  3 each  source A, source B, destination register.
REQ-009 rf_raddr_a / rf_raddr_b  out  3 each  register-file read addresses.
REQ-010 alu_control_command  out  8  ALU opcode.
REQ-011 rf_waddr  out  3;  rf_we  out  1  register-file write address / enable.
REQ-012 done  out  1  one-cycle pulse per retired legal instruction.
REQ-013 illegal  out  1  one-cycle pulse per discarded illegal instruction.
REQ-014 busy  out  1  high when state != IDLE or queue non-empty.

Function
REQ-015 Push on rising edge when instr_valid && instr_ready; {cmd, rs1, rs2, rd} stored FIFO order.
REQ-016 Queue full: instr_ready=0, no push, no overwrite; push+pop same edge when not full both occur, count unchanged.
REQ-017 States IDLE, READ, EXEC, WB; single pop point: edge leaving IDLE or WB with queue non-empty, popped entry loaded into current-instruction register.
REQ-018 IDLE: queue non-empty -> pop; legal cmd -> READ, illegal cmd -> IDLE with illegal=1 next cycle; empty -> stay.
REQ-019 READ (1 cycle): rf_raddr_a=rs1, rf_raddr_b=rs2; -> EXEC.
REQ-020 EXEC: rf_raddrs held; alu_control_command=cmd[7:0]; 1 cycle, except cmd 0x0003 (MUL) held exactly MUL_CYCLES cycles via down-counter; then -> WB.
REQ-021 WB (1 cycle): rf_waddr=rd, done=1; rf_we=1 except cmd 0x000D-0x000F (counter ops, rf_we=0); queue non-empty -> pop, READ (or IDLE+illegal pulse if popped cmd illegal); else -> IDLE.
REQ-022 Outside READ/EXEC rf_raddr_a/b=0; outside EXEC alu_control_command=0; outside WB rf_waddr=0, rf_we=0, done=0.
REQ-023 Latency: push at edge N -> READ after edge N+1, EXEC after N+2, WB (rf_we, done) after N+3 (non-MUL, idle, empty queue).
REQ-024 Back-to-back throughput: one non-MUL instruction per 3 cycles; MUL adds MUL_CYCLES-1.
REQ-025 Illegal instruction consumes the pop cycle only; never drives rf_we, alu_control_command or done.
REQ-026 done and illegal never high in the same cycle; at most one pop per edge.

Reset
REQ-027 reset_n=0 at an edge: state=IDLE, queue empty, counters 0, all outputs 0 except instr_ready=1 (held 0 during reset cycles); in-flight instruction dropped, no rf_we.
REQ-028 Push attempts while reset_n=0 are ignored.

Verification
REQ-029 Single ADD: push {0x0001,rs1=1,rs2=2,rd=3} at edge 0 -> raddr 1/2 in cycle 1, alu cmd 0x01 cycle 2, rf_we=1 rf_waddr=3 done=1 cycle 3 only.
REQ-030 MUL with MUL_CYCLES=3: alu cmd 0x03 exactly 3 cycles, WB in cycle 5 after push.
REQ-031 Fill: 5 pushes while stalled on MUL -> instr_ready=0 after 4 queued (incl. pop timing), all retire in order, rd sequence matches.
REQ-032 Illegal 0x0011 between two ADDs -> one illegal pulse, no write for it, ADDs retire with rf_we, done count=2.
REQ-033 Counter op 0x000E -> alu cmd 0x0E in EXEC, done=1, rf_we=0.
REQ-034 reset_n=0 during EXEC of queued stream -> next cycle all outputs 0, busy=0, no later rf_we without new pushes.
